// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched micro-ops, wakes them from the CDB, issues oldest-ready.
// Optional RS_CDB_BYPASS_EN lets select see this cycle's CDB broadcast directly.
package alu_rs_pkg;
    localparam int GPR_SIZE     = 32;
    localparam int ROB_IDX_SIZE = 4;

    typedef enum logic [3:0] {
        ALU_PLUS, ALU_MINUS, ALU_AND, ALU_OR,
        ALU_XOR, ALU_SHL, ALU_SHR, ALU_MOV
    } alu_op_t;

    typedef logic [3:0] nzcv_t;

    typedef struct packed {
        logic                    valid;
        alu_op_t                 op;
        logic                    a_rdy;
        logic [GPR_SIZE-1:0]     a_val;
        logic [ROB_IDX_SIZE-1:0] a_tag;
        logic                    b_rdy;
        logic [GPR_SIZE-1:0]     b_val;
        logic [ROB_IDX_SIZE-1:0] b_tag;
        logic                    n_rdy;
        nzcv_t                   n_val;
        logic [ROB_IDX_SIZE-1:0] n_tag;
        logic                    set_nzcv;
        logic [ROB_IDX_SIZE-1:0] dst;
    } rs_entry_t;
endpackage

module alu_reservation_station
    import alu_rs_pkg::*;
#(
    parameter  int NUM_ENTRIES = 4,
    localparam int AGE_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_flush,
    input  logic                    in_dispatch_valid,
    input  alu_op_t                 in_dispatch_op,
    input  logic                    in_dispatch_a_ready,
    input  logic [GPR_SIZE-1:0]     in_dispatch_a_val,
    input  logic [ROB_IDX_SIZE-1:0] in_dispatch_a_tag,
    input  logic                    in_dispatch_b_ready,
    input  logic [GPR_SIZE-1:0]     in_dispatch_b_val,
    input  logic [ROB_IDX_SIZE-1:0] in_dispatch_b_tag,
    input  logic                    in_dispatch_nzcv_ready,
    input  nzcv_t                   in_dispatch_nzcv,
    input  logic [ROB_IDX_SIZE-1:0] in_dispatch_nzcv_tag,
    input  logic                    in_dispatch_set_nzcv,
    input  logic [ROB_IDX_SIZE-1:0] in_dispatch_dst_rob_index,
    input  logic                    in_cdb_valid,
    input  logic [ROB_IDX_SIZE-1:0] in_cdb_rob_index,
    input  logic [GPR_SIZE-1:0]     in_cdb_value,
    input  logic                    in_cdb_set_nzcv,
    input  nzcv_t                   in_cdb_nzcv,
    input  logic                    in_fu_alu_ready,
    output logic                    out_dispatch_ready,
    output logic [AGE_W:0]          out_count,
    output logic                    out_alu_start,
    output alu_op_t                 out_alu_op,
    output logic [GPR_SIZE-1:0]     out_alu_val_a,
    output logic [GPR_SIZE-1:0]     out_alu_val_b,
    output logic [ROB_IDX_SIZE-1:0] out_alu_dst_rob_index,
    output logic                    out_alu_set_nzcv,
    output nzcv_t                   out_alu_nzcv
);
`ifdef RS_CDB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    rs_entry_t        ent [NUM_ENTRIES];
    logic [AGE_W-1:0] age [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] a_hit, b_hit, n_hit, rdy;
    logic                   sel_any, alloc_any, issue, accept;
    logic [AGE_W-1:0]       sel_idx, sel_age, alloc_idx;
    logic [GPR_SIZE-1:0]    sel_a, sel_b;
    nzcv_t                  sel_n;
    logic [AGE_W:0]         cnt_after, next_count;
    rs_entry_t              new_ent;
    logic                   d_a_hit, d_b_hit, d_n_hit;

    always_comb begin
        sel_any   = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        alloc_any = 1'b0;
        alloc_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            a_hit[i] = in_cdb_valid && !ent[i].a_rdy
                       && (ent[i].a_tag == in_cdb_rob_index);
            b_hit[i] = in_cdb_valid && !ent[i].b_rdy
                       && (ent[i].b_tag == in_cdb_rob_index);
            n_hit[i] = in_cdb_valid && in_cdb_set_nzcv && !ent[i].n_rdy
                       && (ent[i].n_tag == in_cdb_rob_index);
            rdy[i] = ent[i].valid
                     && (ent[i].a_rdy || (BYPASS && a_hit[i]))
                     && (ent[i].b_rdy || (BYPASS && b_hit[i]))
                     && (ent[i].n_rdy || (BYPASS && n_hit[i]));
            if (rdy[i] && (!sel_any || age[i] < sel_age)) begin
                sel_any = 1'b1;
                sel_idx = AGE_W'(i);
                sel_age = age[i];
            end
            if (!alloc_any && !ent[i].valid) begin
                alloc_any = 1'b1;
                alloc_idx = AGE_W'(i);
            end
        end
    end

    always_comb begin
        sel_a = (BYPASS && a_hit[sel_idx]) ? in_cdb_value : ent[sel_idx].a_val;
        sel_b = (BYPASS && b_hit[sel_idx]) ? in_cdb_value : ent[sel_idx].b_val;
        sel_n = (BYPASS && n_hit[sel_idx]) ? in_cdb_nzcv  : ent[sel_idx].n_val;
    end

    assign issue      = in_fu_alu_ready && sel_any && !in_flush;
    assign accept     = in_dispatch_valid && out_dispatch_ready && !in_flush;
    assign cnt_after  = out_count - (AGE_W+1)'(issue);
    assign next_count = cnt_after + (AGE_W+1)'(accept);

    // A dispatching op can catch a broadcast of its producer in the same cycle.
    assign d_a_hit = in_cdb_valid && !in_dispatch_a_ready
                     && (in_dispatch_a_tag == in_cdb_rob_index);
    assign d_b_hit = in_cdb_valid && !in_dispatch_b_ready
                     && (in_dispatch_b_tag == in_cdb_rob_index);
    assign d_n_hit = in_cdb_valid && in_cdb_set_nzcv && !in_dispatch_nzcv_ready
                     && (in_dispatch_nzcv_tag == in_cdb_rob_index);

    always_comb begin
        new_ent          = '0;
        new_ent.valid    = 1'b1;
        new_ent.op       = in_dispatch_op;
        new_ent.a_rdy    = in_dispatch_a_ready || d_a_hit;
        new_ent.a_val    = d_a_hit ? in_cdb_value : in_dispatch_a_val;
        new_ent.a_tag    = in_dispatch_a_tag;
        new_ent.b_rdy    = in_dispatch_b_ready || d_b_hit;
        new_ent.b_val    = d_b_hit ? in_cdb_value : in_dispatch_b_val;
        new_ent.b_tag    = in_dispatch_b_tag;
        new_ent.n_rdy    = in_dispatch_nzcv_ready || d_n_hit;
        new_ent.n_val    = d_n_hit ? in_cdb_nzcv : in_dispatch_nzcv;
        new_ent.n_tag    = in_dispatch_nzcv_tag;
        new_ent.set_nzcv = in_dispatch_set_nzcv;
        new_ent.dst      = in_dispatch_dst_rob_index;
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent[i] <= '0;
                age[i] <= '0;
            end
            out_count             <= '0;
            out_dispatch_ready    <= 1'b1;
            out_alu_start         <= 1'b0;
            out_alu_op            <= ALU_PLUS;
            out_alu_val_a         <= '0;
            out_alu_val_b         <= '0;
            out_alu_dst_rob_index <= '0;
            out_alu_set_nzcv      <= 1'b0;
            out_alu_nzcv          <= '0;
        end else if (in_flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++)
                ent[i].valid <= 1'b0;
            out_count          <= '0;
            out_dispatch_ready <= 1'b1;
            out_alu_start      <= 1'b0;
        end else begin
            out_alu_start <= issue;
            if (issue) begin
                out_alu_op            <= ent[sel_idx].op;
                out_alu_val_a         <= sel_a;
                out_alu_val_b         <= sel_b;
                out_alu_dst_rob_index <= ent[sel_idx].dst;
                out_alu_set_nzcv      <= ent[sel_idx].set_nzcv;
                out_alu_nzcv          <= sel_n;
            end
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (ent[i].valid && a_hit[i]) begin
                    ent[i].a_rdy <= 1'b1;
                    ent[i].a_val <= in_cdb_value;
                end
                if (ent[i].valid && b_hit[i]) begin
                    ent[i].b_rdy <= 1'b1;
                    ent[i].b_val <= in_cdb_value;
                end
                if (ent[i].valid && n_hit[i]) begin
                    ent[i].n_rdy <= 1'b1;
                    ent[i].n_val <= in_cdb_nzcv;
                end
                if (issue && ent[i].valid && age[i] > sel_age)
                    age[i] <= age[i] - 1'b1;
                if (issue && AGE_W'(i) == sel_idx)
                    ent[i].valid <= 1'b0;
            end
            // Only slots free in registered state are allocated; an issuing slot waits a cycle.
            if (accept) begin
                ent[alloc_idx] <= new_ent;
                age[alloc_idx] <= cnt_after[AGE_W-1:0];
            end
            out_count          <= next_count;
            out_dispatch_ready <= next_count < (AGE_W+1)'(NUM_ENTRIES);
        end
    end

    always @(posedge in_clk) begin
        if (!in_rst)
            assert (!(in_dispatch_valid && !out_dispatch_ready && !in_flush))
            else $warning("dispatch dropped: station full");
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station.
// Expected values are hand-derived; RS_CDB_BYPASS_EN shifts wakeup latency by one cycle.
module tb_alu_reservation_station;
    import alu_rs_pkg::*;

`ifdef RS_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                    in_clk = 1'b0;
    logic                    in_rst = 1'b1;
    logic                    in_flush = 1'b0;
    logic                    in_dispatch_valid = 1'b0;
    alu_op_t                 in_dispatch_op = ALU_PLUS;
    logic                    in_dispatch_a_ready = 1'b0;
    logic [GPR_SIZE-1:0]     in_dispatch_a_val = '0;
    logic [ROB_IDX_SIZE-1:0] in_dispatch_a_tag = '0;
    logic                    in_dispatch_b_ready = 1'b0;
    logic [GPR_SIZE-1:0]     in_dispatch_b_val = '0;
    logic [ROB_IDX_SIZE-1:0] in_dispatch_b_tag = '0;
    logic                    in_dispatch_nzcv_ready = 1'b0;
    nzcv_t                   in_dispatch_nzcv = '0;
    logic [ROB_IDX_SIZE-1:0] in_dispatch_nzcv_tag = '0;
    logic                    in_dispatch_set_nzcv = 1'b0;
    logic [ROB_IDX_SIZE-1:0] in_dispatch_dst_rob_index = '0;
    logic                    in_cdb_valid = 1'b0;
    logic [ROB_IDX_SIZE-1:0] in_cdb_rob_index = '0;
    logic [GPR_SIZE-1:0]     in_cdb_value = '0;
    logic                    in_cdb_set_nzcv = 1'b0;
    nzcv_t                   in_cdb_nzcv = '0;
    logic                    in_fu_alu_ready = 1'b1;
    logic                    out_dispatch_ready;
    logic [2:0]              out_count;
    logic                    out_alu_start;
    alu_op_t                 out_alu_op;
    logic [GPR_SIZE-1:0]     out_alu_val_a;
    logic [GPR_SIZE-1:0]     out_alu_val_b;
    logic [ROB_IDX_SIZE-1:0] out_alu_dst_rob_index;
    logic                    out_alu_set_nzcv;
    nzcv_t                   out_alu_nzcv;

    int n_cmp = 0;
    int n_bad = 0;

    alu_reservation_station #(.NUM_ENTRIES(4)) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_flush(in_flush),
        .in_dispatch_valid(in_dispatch_valid),
        .in_dispatch_op(in_dispatch_op),
        .in_dispatch_a_ready(in_dispatch_a_ready),
        .in_dispatch_a_val(in_dispatch_a_val),
        .in_dispatch_a_tag(in_dispatch_a_tag),
        .in_dispatch_b_ready(in_dispatch_b_ready),
        .in_dispatch_b_val(in_dispatch_b_val),
        .in_dispatch_b_tag(in_dispatch_b_tag),
        .in_dispatch_nzcv_ready(in_dispatch_nzcv_ready),
        .in_dispatch_nzcv(in_dispatch_nzcv),
        .in_dispatch_nzcv_tag(in_dispatch_nzcv_tag),
        .in_dispatch_set_nzcv(in_dispatch_set_nzcv),
        .in_dispatch_dst_rob_index(in_dispatch_dst_rob_index),
        .in_cdb_valid(in_cdb_valid),
        .in_cdb_rob_index(in_cdb_rob_index),
        .in_cdb_value(in_cdb_value),
        .in_cdb_set_nzcv(in_cdb_set_nzcv),
        .in_cdb_nzcv(in_cdb_nzcv),
        .in_fu_alu_ready(in_fu_alu_ready),
        .out_dispatch_ready(out_dispatch_ready),
        .out_count(out_count),
        .out_alu_start(out_alu_start),
        .out_alu_op(out_alu_op),
        .out_alu_val_a(out_alu_val_a),
        .out_alu_val_b(out_alu_val_b),
        .out_alu_dst_rob_index(out_alu_dst_rob_index),
        .out_alu_set_nzcv(out_alu_set_nzcv),
        .out_alu_nzcv(out_alu_nzcv)
    );

    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge in_clk);
    endtask

    task automatic idle();
        in_dispatch_valid = 1'b0;
        in_cdb_valid      = 1'b0;
        in_cdb_set_nzcv   = 1'b0;
        in_flush          = 1'b0;
    endtask

    task automatic disp(input alu_op_t op,
                        input logic ar, input logic [31:0] av, input logic [3:0] at,
                        input logic br, input logic [31:0] bv, input logic [3:0] bt,
                        input logic nr, input nzcv_t nv, input logic [3:0] nt,
                        input logic sn, input logic [3:0] dst);
        in_dispatch_valid         = 1'b1;
        in_dispatch_op            = op;
        in_dispatch_a_ready       = ar;
        in_dispatch_a_val         = av;
        in_dispatch_a_tag         = at;
        in_dispatch_b_ready       = br;
        in_dispatch_b_val         = bv;
        in_dispatch_b_tag         = bt;
        in_dispatch_nzcv_ready    = nr;
        in_dispatch_nzcv          = nv;
        in_dispatch_nzcv_tag      = nt;
        in_dispatch_set_nzcv      = sn;
        in_dispatch_dst_rob_index = dst;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] v,
                       input logic sn, input nzcv_t nz);
        in_cdb_valid     = 1'b1;
        in_cdb_rob_index = tag;
        in_cdb_value     = v;
        in_cdb_set_nzcv  = sn;
        in_cdb_nzcv      = nz;
    endtask

    initial begin
        // reset state
        tick();
        chk("rst_start", 64'(out_alu_start), 0);
        chk("rst_count", 64'(out_count), 0);
        chk("rst_dready", 64'(out_dispatch_ready), 1);
        chk("rst_val_a", 64'(out_alu_val_a), 0);
        chk("rst_dst", 64'(out_alu_dst_rob_index), 0);
        in_rst = 1'b0;

        // all-ready dispatch: start one cycle after the dispatch edge
        disp(ALU_PLUS, 1, 5, 0, 1, 7, 0, 1, 0, 0, 0, 3);
        tick();
        idle();
        chk("t2_start0", 64'(out_alu_start), 0);
        chk("t2_count1", 64'(out_count), 1);
        tick();
        chk("t2_start", 64'(out_alu_start), 1);
        chk("t2_op", 64'(out_alu_op), 64'(ALU_PLUS));
        chk("t2_val_a", 64'(out_alu_val_a), 5);
        chk("t2_val_b", 64'(out_alu_val_b), 7);
        chk("t2_dst", 64'(out_alu_dst_rob_index), 3);
        tick();
        chk("t2_start_off", 64'(out_alu_start), 0);
        chk("t2_count0", 64'(out_count), 0);

        // operand B waits on tag 2
        disp(ALU_MINUS, 1, 20, 0, 0, 0, 2, 1, 0, 0, 0, 4);
        tick();
        idle();
        chk("t3_count", 64'(out_count), 1);
        tick();
        chk("t3_wait", 64'(out_alu_start), 0);
        cdb(2, 9, 0, 0);
        tick();
        idle();
        if (BYP) begin
            chk("t3_start", 64'(out_alu_start), 1);
            chk("t3_val_b", 64'(out_alu_val_b), 9);
            tick();
            chk("t3_start_off", 64'(out_alu_start), 0);
        end else begin
            chk("t3_start_early", 64'(out_alu_start), 0);
            tick();
            chk("t3_start", 64'(out_alu_start), 1);
            chk("t3_val_b", 64'(out_alu_val_b), 9);
        end
        chk("t3_val_a", 64'(out_alu_val_a), 20);
        chk("t3_dst", 64'(out_alu_dst_rob_index), 4);
        tick();
        chk("t3_count0", 64'(out_count), 0);

        // fill the station with entries waiting on tag 6
        for (int i = 0; i < 4; i++) begin
            disp(ALU_AND, 0, 0, 6, 1, 32'(8 + i), 0, 1, 0, 0, 0, 4'(8 + i));
            tick();
        end
        idle();
        chk("t4_count4", 64'(out_count), 4);
        chk("t4_dready0", 64'(out_dispatch_ready), 0);
        disp(ALU_OR, 1, 1, 0, 1, 1, 0, 1, 0, 0, 0, 12);
        tick();
        idle();
        chk("t4_full_count", 64'(out_count), 4);
        chk("t4_full_start", 64'(out_alu_start), 0);
        cdb(6, 100, 0, 0);
        tick();
        idle();
        if (BYP) begin
            chk("t4_i0_start", 64'(out_alu_start), 1);
            chk("t4_i0_dst", 64'(out_alu_dst_rob_index), 8);
        end else begin
            chk("t4_i0_wait", 64'(out_alu_start), 0);
        end
        for (int j = (BYP ? 1 : 0); j < 4; j++) begin
            tick();
            chk("t4_start", 64'(out_alu_start), 1);
            chk("t4_dst", 64'(out_alu_dst_rob_index), 64'(8 + j));
            chk("t4_val_a", 64'(out_alu_val_a), 100);
            chk("t4_val_b", 64'(out_alu_val_b), 64'(8 + j));
        end
        tick();
        chk("t4_done", 64'(out_alu_start), 0);
        chk("t4_count0", 64'(out_count), 0);
        chk("t4_dready1", 64'(out_dispatch_ready), 1);

        // ALU busy: two ready ops held, then issued oldest first
        in_fu_alu_ready = 1'b0;
        disp(ALU_XOR, 1, 11, 0, 1, 12, 0, 1, 0, 0, 0, 1);
        tick();
        chk("t5_s0", 64'(out_alu_start), 0);
        disp(ALU_SHL, 1, 21, 0, 1, 22, 0, 1, 0, 0, 0, 2);
        tick();
        idle();
        chk("t5_s1", 64'(out_alu_start), 0);
        chk("t5_count2", 64'(out_count), 2);
        tick();
        chk("t5_s2", 64'(out_alu_start), 0);
        in_fu_alu_ready = 1'b1;
        tick();
        chk("t5_first", 64'(out_alu_dst_rob_index), 1);
        chk("t5_first_start", 64'(out_alu_start), 1);
        chk("t5_first_a", 64'(out_alu_val_a), 11);
        tick();
        chk("t5_second", 64'(out_alu_dst_rob_index), 2);
        chk("t5_second_start", 64'(out_alu_start), 1);
        chk("t5_second_op", 64'(out_alu_op), 64'(ALU_SHL));
        tick();
        chk("t5_done", 64'(out_alu_start), 0);

        // NZCV wakes only on a broadcast that carries NZCV
        disp(ALU_MOV, 1, 3, 0, 1, 4, 0, 0, 0, 5, 1, 7);
        tick();
        idle();
        chk("t7_count", 64'(out_count), 1);
        cdb(5, 0, 0, 4'hF);
        tick();
        idle();
        chk("t7_no_wake", 64'(out_alu_start), 0);
        cdb(5, 0, 1, 4'hA);
        tick();
        idle();
        if (!BYP) begin
            chk("t7_wait", 64'(out_alu_start), 0);
            tick();
        end
        chk("t7_start", 64'(out_alu_start), 1);
        chk("t7_nzcv", 64'(out_alu_nzcv), 64'hA);
        chk("t7_setn", 64'(out_alu_set_nzcv), 1);
        tick();

        // flush beats dispatch and issue
        in_fu_alu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(ALU_PLUS, 1, 32'(i), 0, 1, 1, 0, 1, 0, 0, 0, 4'(i));
            tick();
        end
        idle();
        chk("t6_count3", 64'(out_count), 3);
        in_fu_alu_ready = 1'b1;
        in_flush = 1'b1;
        disp(ALU_PLUS, 1, 1, 0, 1, 1, 0, 1, 0, 0, 0, 9);
        tick();
        idle();
        chk("t6_count0", 64'(out_count), 0);
        chk("t6_start0", 64'(out_alu_start), 0);
        chk("t6_dready", 64'(out_dispatch_ready), 1);
        tick();
        chk("t6_no_alloc_start", 64'(out_alu_start), 0);
        chk("t6_no_alloc_count", 64'(out_count), 0);

        // async reset while an issue pulse is high and an entry waits
        disp(ALU_OR, 0, 0, 9, 1, 0, 0, 1, 0, 0, 0, 5);
        tick();
        disp(ALU_OR, 1, 33, 0, 1, 44, 0, 1, 0, 0, 0, 6);
        tick();
        idle();
        tick();
        chk("t1_pre_start", 64'(out_alu_start), 1);
        chk("t1_pre_count", 64'(out_count), 1);
        #2 in_rst = 1'b1;
        #1;
        chk("t1_start", 64'(out_alu_start), 0);
        chk("t1_count", 64'(out_count), 0);
        chk("t1_dready", 64'(out_dispatch_ready), 1);
        chk("t1_val_a", 64'(out_alu_val_a), 0);
        tick();
        in_rst = 1'b0;
        tick();
        chk("t1_after_count", 64'(out_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
